// File: rtl/stopwatch_datapath_pkg.sv
// rtl/stopwatch_datapath_pkg.sv - shared widths and limits for the stopwatch counters
package stopwatch_pkg;
    localparam int MSEC_W   = 7;
    localparam int SEC_W    = 6;
    localparam int MIN_W    = 6;
    localparam int HOUR_W   = 5;

    localparam int MSEC_MAX = 99;
    localparam int SEC_MAX  = 59;
    localparam int MIN_MAX  = 59;
    localparam int HOUR_MAX = 23;
endpackage

// File: rtl/stopwatch_datapath_if.sv
// rtl/stopwatch_datapath_if.sv - controller/datapath run-clear inputs and time outputs
interface stopwatch_datapath_if;
    import stopwatch_pkg::*;

    logic              run_stop;
    logic              clear;
    logic [MSEC_W-1:0] msec;
    logic [SEC_W-1:0]  sec;
    logic [MIN_W-1:0]  min;
    logic [HOUR_W-1:0] hour;
    logic              tick;

    modport master (output run_stop, clear, input msec, sec, min, hour, tick);
    modport slave  (input run_stop, clear, output msec, sec, min, hour, tick);
endinterface

// File: rtl/stopwatch_datapath_sw_mod_counter.sv
// rtl/stopwatch_datapath_sw_mod_counter.sv - modulo-(MAX+1) counter with clear and combinational carry
module sw_mod_counter #(
    parameter int WIDTH = 7,
    parameter int MAX   = 99
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] cnt,
    output logic             carry
);
    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;
    logic             at_max;

    assign at_max = (cnt_q == WIDTH'(MAX));

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = at_max ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Unregistered so a whole chain can roll over on one edge.
    assign carry = inc && !clr && at_max;
    assign cnt   = cnt_q;
endmodule

// File: rtl/stopwatch_datapath.sv
// rtl/stopwatch_datapath.sv - centisecond prescaler plus cascaded time counters
// Optional hour counter enabled by STOPWATCH_HOUR_EN.
module stopwatch_datapath
    import stopwatch_pkg::*;
#(
    parameter int CLK_FREQ = 100_000_000,
    parameter int TICK_HZ  = 100
) (
    input logic                 clk,
    input logic                 rst,
    stopwatch_datapath_if.slave bus
);
    localparam int DIV   = CLK_FREQ / TICK_HZ;
    localparam int DIV_W = $clog2(DIV);

    logic [DIV_W-1:0] div_cnt_q;
    logic [DIV_W-1:0] div_cnt_d;
    logic             terminal;
    logic             tick_c;
    logic             c0;
    logic             c1;

    assign terminal = (div_cnt_q == DIV_W'(DIV - 1));
    assign tick_c   = bus.run_stop && terminal && !bus.clear;

    // Stopping holds the partial period so resume continues where it left off.
    always_comb begin
        div_cnt_d = div_cnt_q;
        if (bus.clear) begin
            div_cnt_d = '0;
        end else if (bus.run_stop) begin
            div_cnt_d = terminal ? '0 : div_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
        end
    end

    sw_mod_counter #(.WIDTH(MSEC_W), .MAX(MSEC_MAX)) u_msec (
        .clk(clk), .rst(rst), .clr(bus.clear), .inc(tick_c), .cnt(bus.msec), .carry(c0)
    );

    sw_mod_counter #(.WIDTH(SEC_W), .MAX(SEC_MAX)) u_sec (
        .clk(clk), .rst(rst), .clr(bus.clear), .inc(c0), .cnt(bus.sec), .carry(c1)
    );

`ifdef STOPWATCH_HOUR_EN
    logic c2;
    logic c3;

    sw_mod_counter #(.WIDTH(MIN_W), .MAX(MIN_MAX)) u_min (
        .clk(clk), .rst(rst), .clr(bus.clear), .inc(c1), .cnt(bus.min), .carry(c2)
    );

    // Hours wrap freely; nothing consumes their carry.
    sw_mod_counter #(.WIDTH(HOUR_W), .MAX(HOUR_MAX)) u_hour (
        .clk(clk), .rst(rst), .clr(bus.clear), .inc(c2), .cnt(bus.hour), .carry(c3)
    );
`else
    sw_mod_counter #(.WIDTH(MIN_W), .MAX(MIN_MAX)) u_min (
        .clk(clk), .rst(rst), .clr(bus.clear), .inc(c1), .cnt(bus.min), .carry()
    );

    assign bus.hour = '0;
`endif

    assign bus.tick = tick_c;
endmodule

// File: tb/tb_stopwatch_datapath.sv
// tb/tb_stopwatch_datapath.sv - scoreboard bench for stopwatch_datapath with DIV=10
module tb_stopwatch_datapath;
    logic clk = 1'b0;
    logic rst;

    stopwatch_datapath_if sw_if();

    stopwatch_datapath #(.CLK_FREQ(1000), .TICK_HZ(100)) dut (
        .clk(clk),
        .rst(rst),
        .bus(sw_if.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        int idx;
        int ms;
        int s;
        int m;
        int h;
    } exp_t;

    exp_t q[$];
    int   checks     = 0;
    int   errors     = 0;
    int   ticks_seen = 0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic push(input int idx, input int ms, input int s, input int m, input int h);
        exp_t e;
        e.idx = idx; e.ms = ms; e.s = s; e.m = m; e.h = h;
        q.push_back(e);
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_tick(output int n);
        n = 0;
        for (int k = 0; k < 30; k++) begin
            n++;
            #1;
            if (sw_if.tick) return;
            cyc();
        end
        n = 999;
    endtask

    // Monitor: on each tick, compare the post-edge time against the queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst || sw_if.clear) begin
                ticks_seen = 0;
            end else if (sw_if.tick) begin
                ticks_seen++;
                if (q.size() > 0 && q[0].idx <= ticks_seen) begin
                    e = q.pop_front();
                    @(posedge clk);
                    #1;
                    checks++;
                    if (e.idx != ticks_seen || int'(sw_if.msec) != e.ms || int'(sw_if.sec) != e.s ||
                        int'(sw_if.min) != e.m || int'(sw_if.hour) != e.h) begin
                        errors++;
                        $display("FAIL sb_tick%0d: got tick%0d %0d:%0d:%0d.%0d expected %0d:%0d:%0d.%0d",
                                 e.idx, ticks_seen, sw_if.hour, sw_if.min, sw_if.sec, sw_if.msec,
                                 e.h, e.m, e.s, e.ms);
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        rst = 1'b1;
        sw_if.run_stop = 1'b0;
        sw_if.clear = 1'b0;
        repeat (2) cyc();
        chk("rst_msec", sw_if.msec, 0);
        chk("rst_sec", sw_if.sec, 0);
        chk("rst_min", sw_if.min, 0);
        chk("rst_hour", sw_if.hour, 0);
        chk("rst_tick", sw_if.tick, 0);

        rst = 1'b0;
        sw_if.run_stop = 1'b1;
        push(1, 1, 0, 0, 0);
        for (int i = 1; i <= 10; i++) begin
            #1;
            chk($sformatf("first_tick_c%0d", i), sw_if.tick, (i == 10) ? 1 : 0);
            cyc();
        end
        chk("first_msec", sw_if.msec, 1);
        chk("first_sec", sw_if.sec, 0);

        push(99, 99, 0, 0, 0);
        push(100, 0, 1, 0, 0);
        push(5999, 99, 59, 0, 0);
        push(6000, 0, 0, 1, 0);
        repeat (59990) cyc();
        chk("run_min", sw_if.min, 1);
        chk("run_sec", sw_if.sec, 0);
        chk("run_msec", sw_if.msec, 0);

        repeat (4) cyc();
        sw_if.run_stop = 1'b0;
        for (int i = 0; i < 7; i++) begin
            #1;
            chk("stop_no_tick", sw_if.tick, 0);
            cyc();
        end
        push(6001, 1, 0, 1, 0);
        sw_if.run_stop = 1'b1;
        wait_tick(n);
        chk("resume_latency", n, 6);
        cyc();
        chk("resume_msec", sw_if.msec, 1);

        sw_if.run_stop = 1'b0;
        force dut.u_min.cnt_d = 6'd0;
        force dut.u_sec.cnt_d = 6'd12;
        force dut.u_msec.cnt_d = 7'd34;
        force dut.div_cnt_d = 4'd9;
        cyc();
        release dut.u_min.cnt_d;
        release dut.u_sec.cnt_d;
        release dut.u_msec.cnt_d;
        release dut.div_cnt_d;
        chk("preload_sec", sw_if.sec, 12);
        chk("preload_msec", sw_if.msec, 34);
        sw_if.clear = 1'b1;
        sw_if.run_stop = 1'b1;
        #1;
        chk("clear_tick_suppressed", sw_if.tick, 0);
        cyc();
        sw_if.clear = 1'b0;
        chk("clear_msec", sw_if.msec, 0);
        chk("clear_sec", sw_if.sec, 0);
        chk("clear_min", sw_if.min, 0);
        chk("clear_hour", sw_if.hour, 0);
        chk("clear_div", dut.div_cnt_q, 0);
        push(1, 1, 0, 0, 0);
        wait_tick(n);
        chk("clear_first_tick", n, 10);
        cyc();

        sw_if.run_stop = 1'b0;
        force dut.u_msec.cnt_d = 7'd99;
        force dut.u_sec.cnt_d = 6'd59;
        force dut.u_min.cnt_d = 6'd59;
`ifdef STOPWATCH_HOUR_EN
        force dut.u_hour.cnt_d = 5'd23;
`endif
        force dut.div_cnt_d = 4'd9;
        cyc();
        release dut.u_msec.cnt_d;
        release dut.u_sec.cnt_d;
        release dut.u_min.cnt_d;
`ifdef STOPWATCH_HOUR_EN
        release dut.u_hour.cnt_d;
        chk("preload_hour", sw_if.hour, 23);
`endif
        release dut.div_cnt_d;
        chk("preload_min", sw_if.min, 59);
        push(ticks_seen + 1, 0, 0, 0, 0);
        sw_if.run_stop = 1'b1;
        #1;
        chk("wrap_tick", sw_if.tick, 1);
        cyc();
        chk("wrap_msec", sw_if.msec, 0);
        chk("wrap_sec", sw_if.sec, 0);
        chk("wrap_min", sw_if.min, 0);
        chk("wrap_hour", sw_if.hour, 0);

        sw_if.clear = 1'b1;
        cyc();
        sw_if.clear = 1'b0;
        push(57, 57, 0, 0, 0);
        repeat (570) cyc();
        chk("pre_rst_msec", sw_if.msec, 57);
        #1;
        rst = 1'b1;
        #1;
        chk("async_rst_msec", sw_if.msec, 0);
        chk("async_rst_sec", sw_if.sec, 0);
        chk("async_rst_tick", sw_if.tick, 0);
        push(1, 1, 0, 0, 0);
        cyc();
        cyc();
        rst = 1'b0;
        repeat (10) cyc();
        chk("post_rst_msec", sw_if.msec, 1);
        chk("post_rst_sec", sw_if.sec, 0);

        repeat (3) cyc();
        chk("sb_empty", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
